jtag_sync_bridge: RTL and testbench
===================================

Name: jtag_sync_bridge

Overview:
Parametrised synchroniser bridge that brings asynchronous debug-side signals into the core clock domain.
- Level channels: N independent bits, each with configurable synchroniser depth, optional glitch filter, and registered rise/fall pulses.
- Data channel: one multi-bit bus crossed with a toggle-request / toggle-ack protocol and a valid/ready interface on the core side.
- Sits between the debug module outputs (halt, reset, register/memory write strobes and data) and the core.

Parameters:
CHANNELS, 4, number of single-bit level channels (>=1)
SYNC_STAGES, 2, flops per synchroniser chain (>=2)
FILTER_CYCLES, 0, consecutive stable cycles required before level_o changes; 0 = filter bypassed
DATA_WIDTH, 32, width of the data channel
RESET_VAL, {CHANNELS{1'b0}}, per-channel reset value of the synchroniser flops and level_o

Ports:
clk  input  1  core clock; the only clock in the block
rst_n  input  1  reset; synchronous, active-low
async_i  input  CHANNELS  asynchronous level inputs
level_o  output  CHANNELS  synchronised (and filtered) levels
rise_o  output  CHANNELS  one-cycle pulse on level_o 0->1
fall_o  output  CHANNELS  one-cycle pulse on level_o 1->0
req_tgl_i  input  1  asynchronous request toggle from source
data_i  input  DATA_WIDTH  source data; held stable by source from before its toggle until it sees ack
data_o  output  DATA_WIDTH  captured data
data_vld_o  output  1  captured data valid
data_rdy_i  input  1  consumer ready
ack_tgl_o  output  1  ack toggle back to source; the source synchronises it
overrun_o  output  1  sticky protocol-violation flag

Behaviour:
Reset (rst_n=0 at a clk edge):
- Level-channel sync flops and level_o take RESET_VAL.
- rise_o, fall_o, data_o, data_vld_o, ack_tgl_o and overrun_o clear to 0.
- Request sync chain, req_seen register and filter counters clear to 0.
- Reset applied mid-transfer abandons the transfer: data_vld_o drops, and ack is not toggled.
- Source and bridge are reset together. A req_tgl_i=1 present after reset is treated as a new request.

Level channels:
- async_i[i] passes through SYNC_STAGES flops; the last stage is sync[i].
- FILTER_CYCLES=0: level_o[i] <= sync[i]. Latency from an async_i change to level_o is SYNC_STAGES+1 edges.
- FILTER_CYCLES=F>0:
  - Each channel has a counter of width clog2(F+1).
  - While sync[i] != level_o[i], the counter increments. When the count reaches F-1 and the mismatch persists, level_o flips and the counter clears.
  - Any cycle with sync[i] == level_o[i] clears the counter.
  - A pulse shorter than F cycles never reaches level_o.
- rise_o/fall_o are registered. They assert in the same cycle level_o shows the new value, for exactly one cycle.
- Channels are fully independent; simultaneous changes on several channels are handled in parallel.

Data channel, 2-state FSM:
- The request toggle passes through SYNC_STAGES flops to give sreq.
- IDLE:
  - If sreq != req_seen: data_o <= data_i, req_seen <= sreq, data_vld_o <= 1, go to VALID.
  - Capture latency is SYNC_STAGES+1 edges after the toggle.
- VALID:
  - data_vld_o stays 1 and data_o stays stable.
  - On a cycle with data_rdy_i=1: data_vld_o <= 0, ack_tgl_o <= ~ack_tgl_o, go to IDLE.
  - If data_rdy_i=1 in the first VALID cycle, the handshake is single-cycle.
  - If sreq != req_seen while in VALID (source toggled again before ack), set overrun_o. overrun_o stays set until reset.
  - The extra toggle is serviced as a normal request after returning to IDLE, but its data integrity is not guaranteed.
- Back-to-back transfers:
  - The minimum request period is bounded by the source's ack synchroniser.
  - The block adds no IDLE dead cycle: an edge seen in the IDLE cycle right after the accept is captured immediately.
- data_o is not cleared on accept; it holds its last value.

Test Plan:
- Reset with RESET_VAL=4'b0101, async_i=4'b0000, then release reset -> level_o=4'b0101 during reset. After release, channels 0 and 2 fall at edge 3 (SYNC_STAGES=2), with fall_o=4'b0101 for 1 cycle.
- FILTER_CYCLES=3: 2-cycle high glitch on async_i[1] -> level_o[1] and rise_o[1] stay 0. A 5-cycle high pulse -> level_o[1]=1 at edge 2+3 after the input change, with a single rise_o pulse.
- data_i=32'hDEADBEEF, toggle req_tgl_i 0->1, data_rdy_i=1 -> data_vld_o=1 for exactly one cycle at edge 3 with data_o=32'hDEADBEEF. ack_tgl_o goes to 1 on the next edge.
- data_rdy_i held 0 for 10 cycles after capture -> data_vld_o=1 and data_o stable throughout, ack_tgl_o unchanged. Raise ready -> one accept and one ack toggle.
- In VALID, toggle req_tgl_i again before ack -> overrun_o=1 and stays 1 through later transfers. Assert rst_n=0 -> overrun_o=0.
- Assert reset while in VALID -> data_vld_o=0 and ack_tgl_o=0 on the next edge. The FSM is in IDLE after release.

Source files
------------

// File: rtl/jtag_sync_bridge.sv
// Brings debug-side asynchronous levels and one toggle-handshaked data bus into clk.
// Level channels get an optional stability filter and registered edge pulses.
module jtag_sync_bridge #(
    parameter int                  CHANNELS      = 4,
    parameter int                  SYNC_STAGES   = 2,
    parameter int                  FILTER_CYCLES = 0,
    parameter int                  DATA_WIDTH    = 32,
    parameter logic [CHANNELS-1:0] RESET_VAL     = {CHANNELS{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CHANNELS-1:0]   async_i,
    output logic [CHANNELS-1:0]   level_o,
    output logic [CHANNELS-1:0]   rise_o,
    output logic [CHANNELS-1:0]   fall_o,
    input  logic                  req_tgl_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_vld_o,
    input  logic                  data_rdy_i,
    output logic                  ack_tgl_o,
    output logic                  overrun_o
);

    typedef enum logic {S_IDLE = 1'b0, S_VALID = 1'b1} state_t;

    logic [SYNC_STAGES-1:0][CHANNELS-1:0] r_lvl_sync;
    logic [CHANNELS-1:0]                  w_sync;
    logic [CHANNELS-1:0]                  w_lvl_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) r_lvl_sync <= {SYNC_STAGES{RESET_VAL}};
        else        r_lvl_sync <= {r_lvl_sync[SYNC_STAGES-2:0], async_i};
    end

    assign w_sync = r_lvl_sync[SYNC_STAGES-1];

    generate
        if (FILTER_CYCLES == 0) begin : g_nofilt
            assign w_lvl_nxt = w_sync;
        end else begin : g_filt
            localparam int CW = $clog2(FILTER_CYCLES + 1);
            for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
                logic [CW-1:0] r_cnt;
                logic          w_mis;
                logic          w_done;
                assign w_mis  = w_sync[i] != level_o[i];
                assign w_done = w_mis && (r_cnt == CW'(FILTER_CYCLES - 1));
                // Counter resets on any agreeing cycle, so only an unbroken run flips the level.
                always_ff @(posedge clk) begin
                    if (!rst_n)                r_cnt <= '0;
                    else if (w_mis && !w_done) r_cnt <= r_cnt + 1'b1;
                    else                       r_cnt <= '0;
                end
                assign w_lvl_nxt[i] = w_done ? w_sync[i] : level_o[i];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_o <= RESET_VAL;
            rise_o  <= '0;
            fall_o  <= '0;
        end else begin
            level_o <= w_lvl_nxt;
            rise_o  <= w_lvl_nxt & ~level_o;
            fall_o  <= ~w_lvl_nxt & level_o;
        end
    end

    logic [SYNC_STAGES-1:0] r_req_sync;
    logic                   r_req_seen;
    logic                   w_sreq;
    logic                   w_new_req;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_capture;
    logic                   w_accept;
    logic                   w_overrun;

    always_ff @(posedge clk) begin
        if (!rst_n) r_req_sync <= '0;
        else        r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], req_tgl_i};
    end

    assign w_sreq    = r_req_sync[SYNC_STAGES-1];
    assign w_new_req = w_sreq != r_req_seen;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_new_req)  w_state_nxt = S_VALID;
            S_VALID: if (data_rdy_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_capture  = (r_state == S_IDLE) && w_new_req;
        w_accept   = (r_state == S_VALID) && data_rdy_i;
        w_overrun  = (r_state == S_VALID) && w_new_req;
        data_vld_o = (r_state == S_VALID);
    end

    // data_o deliberately holds its last value after accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_o     <= '0;
            r_req_seen <= 1'b0;
            ack_tgl_o  <= 1'b0;
            overrun_o  <= 1'b0;
        end else begin
            if (w_capture) begin
                data_o     <= data_i;
                r_req_seen <= w_sreq;
            end
            if (w_accept)  ack_tgl_o <= ~ack_tgl_o;
            if (w_overrun) overrun_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_jtag_sync_bridge.sv
// Directed bench: unfiltered bridge with RESET_VAL=0101 and a FILTER_CYCLES=3 bridge.
// Data transfers are scoreboarded through a queue of expected captures.
module tb_jtag_sync_bridge;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [3:0]  a_async, a_level, a_rise, a_fall;
    logic        a_req, a_vld, a_rdy, a_ack, a_ovr;
    logic [31:0] a_data, a_dout;

    logic [3:0]  b_async, b_level, b_rise, b_fall;
    logic        b_req, b_vld, b_rdy, b_ack, b_ovr;
    logic [31:0] b_data, b_dout;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] sb_q[$];
    logic [31:0] exp_d;

    initial forever #5 clk = ~clk;

    jtag_sync_bridge #(
        .CHANNELS(4), .SYNC_STAGES(2), .FILTER_CYCLES(0), .DATA_WIDTH(32), .RESET_VAL(4'b0101)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .async_i(a_async), .level_o(a_level), .rise_o(a_rise),
        .fall_o(a_fall), .req_tgl_i(a_req), .data_i(a_data), .data_o(a_dout),
        .data_vld_o(a_vld), .data_rdy_i(a_rdy), .ack_tgl_o(a_ack), .overrun_o(a_ovr)
    );

    jtag_sync_bridge #(
        .CHANNELS(4), .SYNC_STAGES(2), .FILTER_CYCLES(3), .DATA_WIDTH(32), .RESET_VAL(4'b0000)
    ) u_flt (
        .clk(clk), .rst_n(rst_n), .async_i(b_async), .level_o(b_level), .rise_o(b_rise),
        .fall_o(b_fall), .req_tgl_i(b_req), .data_i(b_data), .data_o(b_dout),
        .data_vld_o(b_vld), .data_rdy_i(b_rdy), .ack_tgl_o(b_ack), .overrun_o(b_ovr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_vld(input int n);
        bit ok = 1'b0;
        for (int i = 0; i < n && !ok; i++) begin
            tick();
            if (a_vld === 1'b1) ok = 1'b1;
        end
        chk("vld_timeout", {31'd0, ok}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        a_async = '0; a_req = 1'b0; a_data = '0; a_rdy = 1'b0;
        b_async = '0; b_req = 1'b0; b_data = '0; b_rdy = 1'b0;
        tick(); tick();
        chk("rst_level",  a_level, 4'b0101);
        chk("rst_rise",   a_rise,  4'b0000);
        chk("rst_fall",   a_fall,  4'b0000);
        chk("rst_vld",    a_vld,   1'b0);
        chk("rst_ack",    a_ack,   1'b0);
        chk("rst_ovr",    a_ovr,   1'b0);
        chk("rst_dout",   a_dout,  32'h0);
        chk("rst_flevel", b_level, 4'b0000);
        chk("rst_fctl",   {b_vld, b_ack, b_ovr}, 3'b000);
        chk("rst_fdout",  b_dout,  32'h0);

        // Release: channels 0 and 2 fall to the sampled 0 at edge 3.
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("rel_level", a_level, (k < 3) ? 4'b0101 : 4'b0000);
            chk("rel_fall",  a_fall,  (k == 3) ? 4'b0101 : 4'b0000);
            chk("rel_rise",  a_rise,  4'b0000);
        end

        // 2-cycle glitch is swallowed by the 3-cycle filter.
        b_async = 4'b0010;
        tick(); tick();
        b_async = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("glitch_level", b_level, 4'b0000);
            chk("glitch_rise",  b_rise,  4'b0000);
        end

        // 5-cycle pulse: level follows 2+3 edges after each input change.
        b_async = 4'b0010;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("pulse_level", b_level, (k >= 5 && k < 10) ? 4'b0010 : 4'b0000);
            chk("pulse_rise",  b_rise,  (k == 5)  ? 4'b0010 : 4'b0000);
            chk("pulse_fall",  b_fall,  (k == 10) ? 4'b0010 : 4'b0000);
            if (k == 5) b_async = 4'b0000;
        end

        // Single-cycle handshake with ready already high.
        a_data = 32'hDEADBEEF; a_rdy = 1'b1; a_req = 1'b1;
        sb_q.push_back(a_data);
        tick(); chk("xfer1_vld_e1", a_vld, 1'b0);
        tick(); chk("xfer1_vld_e2", a_vld, 1'b0);
        tick(); chk("xfer1_vld_e3", a_vld, 1'b1);
        exp_d = sb_q.pop_front();
        chk("xfer1_data", a_dout, exp_d);
        chk("xfer1_ack0", a_ack, 1'b0);
        tick(); chk("xfer1_vld_e4", a_vld, 1'b0);
        chk("xfer1_ack1", a_ack, 1'b1);

        // Stalled consumer for 10 cycles.
        a_rdy = 1'b0; a_data = 32'h12345678; a_req = 1'b0;
        sb_q.push_back(a_data);
        wait_vld(10);
        for (int k = 0; k < 10; k++) begin
            chk("stall_vld",  a_vld,  1'b1);
            chk("stall_data", a_dout, sb_q[0]);
            chk("stall_ack",  a_ack,  1'b1);
            tick();
        end
        a_rdy = 1'b1;
        exp_d = sb_q.pop_front();
        chk("stall_acc_data", a_dout, exp_d);
        tick();
        chk("stall_acc_vld", a_vld, 1'b0);
        chk("stall_acc_ack", a_ack, 1'b0);
        a_rdy = 1'b0;
        tick();
        chk("stall_idle_vld", a_vld, 1'b0);
        chk("stall_idle_ack", a_ack, 1'b0);

        // Second toggle while VALID sets the sticky overrun flag.
        a_data = 32'hA5A50001; a_req = 1'b1;
        sb_q.push_back(a_data);
        wait_vld(10);
        chk("ovr_before", a_ovr, 1'b0);
        a_data = 32'h5A5A0002; a_req = 1'b0;
        sb_q.push_back(a_data);
        tick(); tick(); tick();
        chk("ovr_set",      a_ovr,  1'b1);
        chk("ovr_vld_held", a_vld,  1'b1);
        chk("ovr_data_hld", a_dout, sb_q[0]);
        a_rdy = 1'b1;
        exp_d = sb_q.pop_front();
        chk("ovr_data1", a_dout, exp_d);
        tick();
        chk("ovr_acc1_vld", a_vld, 1'b0);
        chk("ovr_acc1_ack", a_ack, 1'b1);
        tick();
        chk("ovr_cap2_vld", a_vld, 1'b1);
        exp_d = sb_q.pop_front();
        chk("ovr_data2", a_dout, exp_d);
        chk("ovr_sticky", a_ovr, 1'b1);
        tick();
        chk("ovr_acc2_vld", a_vld, 1'b0);
        chk("ovr_acc2_ack", a_ack, 1'b0);
        chk("ovr_sticky2",  a_ovr, 1'b1);
        a_rdy = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("ovr_rst_ovr", a_ovr, 1'b0);
        chk("ovr_rst_vld", a_vld, 1'b0);
        chk("ovr_rst_ack", a_ack, 1'b0);

        // Reset while VALID abandons the transfer.
        rst_n = 1'b1;
        tick(); tick();
        chk("mid_pre_vld", a_vld, 1'b0);
        a_data = 32'hCAFEF00D; a_req = 1'b1;
        sb_q.push_back(a_data);
        wait_vld(10);
        chk("mid_ack_pre", a_ack, 1'b0);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_vld", a_vld, 1'b0);
        chk("mid_rst_ack", a_ack, 1'b0);
        sb_q.delete();
        a_req = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("mid_idle_vld", a_vld, 1'b0);
            chk("mid_idle_ack", a_ack, 1'b0);
        end

        // Fresh transfer after the abandoned one.
        a_data = 32'h0BADCAFE; a_rdy = 1'b1; a_req = 1'b1;
        sb_q.push_back(a_data);
        tick(); tick();
        chk("post_vld_e2", a_vld, 1'b0);
        tick();
        chk("post_vld_e3", a_vld, 1'b1);
        exp_d = sb_q.pop_front();
        chk("post_data", a_dout, exp_d);
        tick();
        chk("post_vld_e4", a_vld, 1'b0);
        chk("post_ack",    a_ack, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
